rf_dump: RTL and testbench
==========================

RF_DUMP -- requirements
Module: rf_dump

Interface
- REQ-001 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
- REQ-002 SHALL have parameter DATA_W, default 32, register data width.
- REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
- REQ-005 SHALL have port start, input, 1, request a dump; sampled only in IDLE.
- REQ-006 SHALL have port abort, input, 1, cancel the dump in progress.
- REQ-007 SHALL have port first_addr, input, ADDR_W, first register to read; latched on accepted start.
- REQ-008 SHALL have port last_addr, input, ADDR_W, last register to read; latched on accepted start.
- REQ-009 SHALL have port rf_addr, output, ADDR_W, registered read address; drives register file port A1.
- REQ-010 SHALL have port rf_rdata, input, DATA_W, combinational read data from register file port RD1.
- REQ-011 SHALL have port out_valid, output, 1, out_addr/out_data hold a valid word.
- REQ-012 SHALL have port out_ready, input, 1, consumer accepts the word.
- REQ-013 SHALL have port out_addr, output, ADDR_W, address of the word on out_data.
- REQ-014 SHALL have port out_data, output, DATA_W, captured register value.
- REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
- REQ-016 SHALL have port done, output, 1, one-cycle pulse after the final word is accepted.

Function
- REQ-017 SHALL implement states IDLE, READ and WAIT; busy SHALL be 1 in READ and WAIT.
- REQ-018 In IDLE, start=1 at an edge SHALL latch first_addr/last_addr, set rf_addr=first_addr and enter READ.
- REQ-019 In READ, the next edge SHALL load out_data<=rf_rdata and out_addr<=rf_addr, set out_valid=1 and enter WAIT.
- REQ-020 In WAIT, out_valid, out_addr and out_data SHALL remain stable while out_ready=0.
- REQ-021 A handshake (out_valid & out_ready at an edge) SHALL clear out_valid.
- REQ-022 On a handshake with rf_addr != last, the block SHALL set rf_addr<=rf_addr+1 mod 2^ADDR_W and enter READ.
- REQ-023 On a handshake with rf_addr == last, the block SHALL enter IDLE and assert done for exactly the following cycle.
- REQ-024 Throughput SHALL be at most one word per 2 cycles; latency from accepted start to first out_valid SHALL be 2 edges.
- REQ-025 If last < first, the address sequence SHALL wrap from 2^ADDR_W-1 to 0; word count = ((last-first) mod 2^ADDR_W)+1.
- REQ-026 If first == last, the block SHALL emit exactly one word.
- REQ-027 start while busy SHALL be ignored, and SHALL not alter the latched addresses.
- REQ-028 abort=1 in READ or WAIT SHALL, at the next edge, enter IDLE with out_valid=0 and done=0; abort SHALL override a simultaneous handshake; abort SHALL be ignored in IDLE.
- REQ-029 start and abort asserted together in IDLE: start SHALL win.
- REQ-030 The block SHALL never drive the register file write port; captured data SHALL be whatever RD1 presents at the READ edge.

Reset
- REQ-031 reset=1 SHALL immediately, without waiting for clk, force state IDLE, rf_addr=0, out_addr=0, out_data=0, out_valid=0, busy=0, done=0.
- REQ-032 Reset during a dump SHALL discard it with no done pulse; a start after reset release SHALL operate normally.

Verification
- REQ-033 Preload x5=0xAAAAAAAA and x6=0x0000FFFF via the rf write port; start first=5, last=6, out_ready=1 -> words (5,0xAAAAAAAA) then (6,0x0000FFFF), one done pulse, then busy=0.
- REQ-034 Start first=30, last=1 -> out_addr sequence 30,31,0,1, 4 handshakes, then done.
- REQ-035 Hold out_ready=0 for 3 cycles in WAIT -> out_valid/out_addr/out_data stable, rf_addr unchanged, then advance on ready.
- REQ-036 Start first=7, last=7 -> exactly one word (7,RD1 value); start pulsed again while busy -> no effect.
- REQ-037 Assert reset mid-WAIT between clock edges -> all outputs 0 before the next edge, no done; a later start with first=0, last=2 -> 3 words.
- REQ-038 Assert abort in WAIT together with out_ready=1 -> next edge IDLE, out_valid=0, done stays 0.

Source files
------------

// File: rtl/rf_dump.sv
// Register-file dump engine: walks an address range on read port A1 and
// streams (address, data) words out over a valid/ready handshake.
module rf_dump #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        rf_addr_d   = rf_addr_q;
        last_d      = last_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // start has priority over abort here; abort means nothing in IDLE
                if (start) begin
                    rf_addr_d = first_addr;
                    last_d    = last_addr;
                    state_d   = READ;
                end
            end
            READ: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_data_d  = rf_rdata;
                    out_addr_d  = rf_addr_q;
                    out_valid_d = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (rf_addr_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rf_addr_d = rf_addr_q + ADDR_W'(1);
                        state_d   = READ;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rf_addr_q   <= '0;
            last_q      <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_addr_q   <= rf_addr_d;
            last_q      <= last_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rf_addr   = rf_addr_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rf_dump.sv
// Scoreboard bench for rf_dump: expected words queued at start,
// a negedge monitor pops and compares on each handshake.
module tb_rf_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          last;
    } exp_t;

    exp_t q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   hs_cnt   = 0;
    int   done_cnt = 0;
    bit   pend_done = 0;
    bit   rdy_rand = 0;

    rf_dump dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    assign rf_rdata = regs[rf_addr];

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Reference: a dump of first..last (mod 32) yields these words in order
    task automatic push_dump(input logic [4:0] f, input logic [4:0] l);
        int n;
        exp_t e;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int k = 0; k < n; k++) begin
            e.a    = 5'((int'(f) + k) % 32);
            e.d    = regs[e.a];
            e.last = (k == n - 1);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pend_done = 0;
        end else begin
            chk("done", done, pend_done);
            if (done) done_cnt++;
            pend_done = 0;
            if (out_valid && out_ready && !abort) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_word", out_addr, 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("out_addr", out_addr, e.a);
                    chk("out_data", out_data, e.d);
                    pend_done = e.last;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom % 4) != 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] f, input logic [4:0] l, input bit ab);
        push_dump(f, l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        abort      = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_rf_addr", rf_addr, f);
        chk("start_valid", out_valid, 0);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
        tick();
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        int h0, d0;
        reset = 1'b1; start = 0; abort = 0;
        first_addr = 0; last_addr = 0; out_ready = 0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[5] = 32'hAAAAAAAA;
        regs[6] = 32'h0000FFFF;
        #1;
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        tick(); tick();
        reset = 1'b0;

        // x5/x6 dump with 2-edge first-word latency
        out_ready = 1;
        h0 = hs_cnt; d0 = done_cnt;
        do_start(5, 6, 0);
        tick();
        chk("latency_valid", out_valid, 1);
        wait_idle(50);
        chk("x56_words", hs_cnt - h0, 2);
        chk("x56_done", done_cnt - d0, 1);

        // wrap-around
        h0 = hs_cnt; d0 = done_cnt;
        do_start(30, 1, 0);
        wait_idle(50);
        chk("wrap_words", hs_cnt - h0, 4);
        chk("wrap_done", done_cnt - d0, 1);

        // backpressure stability
        out_ready = 0;
        do_start(10, 12, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_addr", out_addr, 10);
            chk("bp_data", out_data, regs[10]);
            chk("bp_rf_addr", rf_addr, 10);
            tick();
        end
        out_ready = 1;
        wait_idle(50);

        // single word, start while busy ignored
        h0 = hs_cnt;
        out_ready = 0;
        do_start(7, 7, 0);
        tick();
        first_addr = 3; last_addr = 9; start = 1;
        tick();
        start = 0;
        chk("busy_start_rf_addr", rf_addr, 7);
        out_ready = 1;
        wait_idle(50);
        chk("single_words", hs_cnt - h0, 1);

        // reset between edges in WAIT, then 0..2
        d0 = done_cnt;
        out_ready = 0;
        do_start(20, 25, 0);
        tick();
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_rf_addr", rf_addr, 0);
        q.delete();
        tick();
        reset = 0;
        tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        out_ready = 1;
        h0 = hs_cnt;
        do_start(0, 2, 0);
        wait_idle(50);
        chk("post_rst_words", hs_cnt - h0, 3);

        // abort with simultaneous handshake
        d0 = done_cnt;
        out_ready = 0;
        do_start(14, 16, 0);
        tick();
        out_ready = 1; abort = 1;
        tick();
        abort = 0;
        q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        tick();
        chk("abort_no_done", done_cnt - d0, 0);

        // abort in IDLE ignored; start+abort in IDLE: start wins
        abort = 1;
        tick();
        abort = 0;
        chk("idle_abort_busy", busy, 0);
        do_start(12, 14, 1);
        wait_idle(50);

        // randomized dumps with random backpressure and aborts
        rdy_rand = 1;
        for (int it = 0; it < 30; it++) begin
            logic [4:0] f, l;
            f = 5'($urandom);
            l = 5'($urandom);
            regs[$urandom % 32] = $urandom;
            do_start(f, l, ($urandom % 5) == 0);
            if (($urandom % 4) == 0) begin
                int k = $urandom % 6;
                for (int j = 0; j < k && busy; j++) tick();
                if (busy) begin
                    abort = 1;
                    tick();
                    abort = 0;
                    q.delete();
                    chk("rand_abort_busy", busy, 0);
                    chk("rand_abort_valid", out_valid, 0);
                end
                tick();
                q.delete();
            end else begin
                wait_idle(500);
            end
        end
        rdy_rand = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
